pre_tu: RTL and testbench

- Pipelined 4x4 input-tile transform for the Winograd F(2,3) convolution datapath.
- Computes Y = B^T·X·B on a signed 4x4 tile: a 1-D transform over each row, then the same 1-D transform over each column of the row results.
- Sits between the tile fetch/buffer and the element-wise multiply array.
- Full precision: DW-bit inputs, DW+2-bit outputs, with no rounding or saturation.

---
 rtl/pre_tu_pkg.sv | 12 +
 rtl/pre_tu_1d.sv | 27 ++
 rtl/pre_tu.sv | 70 +++++++
 tb/tb_pre_tu.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pre_tu_pkg.sv
// Shared constants and tile index helpers for the Winograd F(2,3) input-tile transform.
package pre_tu_pkg;

    localparam int TILE  = 4;
    localparam int NELEM = 16;

    // Row-major flat index of element (i, j) within a 4x4 tile.
    function automatic int idx(input int i, input int j);
        return TILE * i + j;
    endfunction

endpackage

// File: rtl/pre_tu_1d.sv
// Combinational 1-D transform T(a,b,c,d) = (a-c, b+c, c-b, b-d), growing one bit.
module pre_tu_1d #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    input  logic signed [W-1:0] d,
    output logic signed [W:0]   y0,
    output logic signed [W:0]   y1,
    output logic signed [W:0]   y2,
    output logic signed [W:0]   y3
);

    logic signed [W:0] ae, be, ce, de;

    assign ae = {a[W-1], a};
    assign be = {b[W-1], b};
    assign ce = {c[W-1], c};
    assign de = {d[W-1], d};

    assign y0 = ae - ce;
    assign y1 = be + ce;
    assign y2 = ce - be;
    assign y3 = be - de;

endmodule

// File: rtl/pre_tu.sv
// Two-stage pipelined 4x4 input-tile transform Y = B^T.X.B (row pass, then column pass).
module pre_tu
    import pre_tu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [16*DW-1:0]         x_in,
    output logic                     out_valid,
    output logic [16*(DW+2)-1:0]     y_out
);

    logic signed [DW-1:0] x   [NELEM];
    logic signed [DW:0]   r_c [NELEM];
    logic signed [DW:0]   r_q [NELEM];
    logic signed [DW+1:0] y_c [NELEM];
    logic signed [DW+1:0] y_q [NELEM];
    logic                 v1;

    for (genvar i = 0; i < TILE; i++) begin : g_row
        for (genvar j = 0; j < TILE; j++) begin : g_elem
            assign x[idx(i, j)] = x_in[idx(i, j)*DW +: DW];
            assign y_out[idx(i, j)*(DW+2) +: DW+2] = y_q[idx(i, j)];
        end

        pre_tu_1d #(.W(DW)) u_row (
            .a  (x[idx(i, 0)]),
            .b  (x[idx(i, 1)]),
            .c  (x[idx(i, 2)]),
            .d  (x[idx(i, 3)]),
            .y0 (r_c[idx(i, 0)]),
            .y1 (r_c[idx(i, 1)]),
            .y2 (r_c[idx(i, 2)]),
            .y3 (r_c[idx(i, 3)])
        );
    end

    // Column pass runs on the registered row results, one extra bit wide.
    for (genvar j = 0; j < TILE; j++) begin : g_col
        pre_tu_1d #(.W(DW+1)) u_col (
            .a  (r_q[idx(0, j)]),
            .b  (r_q[idx(1, j)]),
            .c  (r_q[idx(2, j)]),
            .d  (r_q[idx(3, j)]),
            .y0 (y_c[idx(0, j)]),
            .y1 (y_c[idx(1, j)]),
            .y2 (y_c[idx(2, j)]),
            .y3 (y_c[idx(3, j)])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
            for (int e = 0; e < NELEM; e++) begin
                r_q[e] <= '0;
                y_q[e] <= '0;
            end
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) r_q <= r_c;
            if (v1)       y_q <= y_c;
        end
    end

endmodule

// File: tb/tb_pre_tu.sv
// Directed and streaming checks of pre_tu against a matrix-product reference model.
module tb_pre_tu;

    localparam int DW = 16;
    localparam int XW = 16*DW;
    localparam int YW = 16*(DW+2);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [XW-1:0] x_in;
    logic          out_valid;
    logic [YW-1:0] y_out;

    int n_chk  = 0;
    int n_pass = 0;

    pre_tu #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x_in      (x_in),
        .out_valid (out_valid),
        .y_out     (y_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [YW-1:0] obs, input logic [YW-1:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic int btc(input int r, input int k);
        case ({r[1:0], k[1:0]})
            4'b0000: return 1;
            4'b0010: return -1;
            4'b0101: return 1;
            4'b0110: return 1;
            4'b1001: return -1;
            4'b1010: return 1;
            4'b1101: return 1;
            4'b1111: return -1;
            default: return 0;
        endcase
    endfunction

    // Reference: Y = BT * X * BT^T by plain integer matrix products.
    function automatic logic [YW-1:0] model(input logic [XW-1:0] t);
        int xm [4][4];
        int tm [4][4];
        int ym;
        logic [YW-1:0] y;
        y = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                xm[i][j] = int'($signed(t[(4*i+j)*DW +: DW]));
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++) begin
                tm[r][j] = 0;
                for (int k = 0; k < 4; k++) tm[r][j] += btc(r, k) * xm[k][j];
            end
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 4; c++) begin
                ym = 0;
                for (int k = 0; k < 4; k++) ym += tm[i][k] * btc(c, k);
                y[(4*i+c)*(DW+2) +: DW+2] = (DW+2)'(ym);
            end
        return y;
    endfunction

    function automatic logic [XW-1:0] fill(input int v);
        logic [XW-1:0] t;
        for (int e = 0; e < 16; e++) t[e*DW +: DW] = DW'(v);
        return t;
    endfunction

    function automatic logic [YW-1:0] only11(input int v);
        logic [YW-1:0] y;
        y = '0;
        y[5*(DW+2) +: DW+2] = (DW+2)'(v);
        return y;
    endfunction

    // Present one tile for one cycle, then wait until it has had time to emerge.
    task automatic run_tile(input logic [XW-1:0] t);
        @(negedge clk); in_valid = 1'b1; x_in = t;
        @(negedge clk); in_valid = 1'b0; x_in = '0;
        @(negedge clk);
    endtask

    logic [XW-1:0] t_asc, t_sgn, t_a, t_b, t_c;
    logic [YW-1:0] y_asc, y_hold;
    int            asc_v [16] = '{0, -16, 0, 0, -4, 34, 2, -4, 0, 8, 0, 0, 0, -16, 0, 0};
    int            sgn_v [16] = '{-1, 2, -3, 4, 5, -6, 7, -8, -9, 10, -11, 12, 13, -14, 15, -16};
    logic          vh [64];
    logic [XW-1:0] th [64];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; x_in = '0;
        repeat (2) @(negedge clk);
        check("reset_valid", YW'(out_valid), '0);
        check("reset_y", y_out, '0);
        rst_n = 1'b1;

        for (int e = 0; e < 16; e++) begin
            t_asc[e*DW +: DW] = DW'(e + 1);
            y_asc[e*(DW+2) +: DW+2] = (DW+2)'(asc_v[e]);
            t_sgn[e*DW +: DW] = DW'(sgn_v[e]);
        end

        run_tile(t_asc);
        check("asc_valid", YW'(out_valid), YW'(1));
        check("asc_y", y_out, y_asc);
        @(negedge clk);
        check("asc_valid_drop", YW'(out_valid), '0);
        check("asc_hold", y_out, y_asc);

        run_tile(t_sgn);
        check("signed_y", y_out, model(t_sgn));

        run_tile('0);
        check("zero_valid", YW'(out_valid), YW'(1));
        check("zero_y", y_out, '0);

        run_tile(fill(-32768));
        check("min_y", y_out, only11(-131072));
        run_tile(fill(32767));
        check("max_y", y_out, only11(131068));

        // Streaming with random gaps; output at cycle c reflects input at c-2.
        y_hold = y_out;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                if (vh[c-2]) y_hold = model(th[c-2]);
                check("stream_valid", YW'(out_valid), YW'(vh[c-2]));
                check("stream_y", y_out, y_hold);
            end
            vh[c] = (c < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int e = 0; e < 16; e++) th[c][e*DW +: DW] = DW'($urandom);
            in_valid = vh[c];
            x_in = th[c];
        end

        // Asynchronous reset with tiles in flight.
        for (int e = 0; e < 16; e++) begin
            t_a[e*DW +: DW] = DW'(3*e - 7);
            t_b[e*DW +: DW] = DW'(100 - 9*e);
            t_c[e*DW +: DW] = DW'(e*e);
        end
        @(negedge clk); in_valid = 1'b1; x_in = t_a;
        @(negedge clk); x_in = t_b;
        @(negedge clk); x_in = t_c;
        check("pre_reset_valid", YW'(out_valid), YW'(1));
        check("pre_reset_y", y_out, model(t_a));
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", YW'(out_valid), '0);
        check("async_reset_y", y_out, '0);
        @(negedge clk); in_valid = 1'b0; x_in = '0; rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_reset_valid", YW'(out_valid), '0);
            check("post_reset_y", y_out, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
